xgmii_tx_framer: RTL and testbench



---
 rtl/xgmii_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps a 64-bit client word stream in start/preamble,
// terminate and inter-frame gap, and aborts frames with /E/ on underrun or link loss.
module xgmii_tx_framer #(
    parameter int IFG_WORDS = 1,
    parameter int CNT_BITS  = 32
) (
    input  logic                mgt_clk,
    input  logic                reset,
    input  logic [63:0]         tx_data,
    input  logic                tx_valid,
    input  logic                tx_end,
    input  logic [2:0]          tx_bytes,
    output logic                tx_ready,
    input  logic                link_up,
    output logic [63:0]         xgmii_txd,
    output logic [7:0]          xgmii_txc,
    output logic [CNT_BITS-1:0] frames_sent,
    output logic [15:0]         abort_count,
    output logic                underrun
);

    localparam logic [63:0] IDLE_WORD  = {8{8'h07}};
    localparam logic [63:0] ERR_WORD   = {8{8'hFE}};
    localparam logic [63:0] TERM_WORD  = {{7{8'h07}}, 8'hFD};
    localparam logic [63:0] START_WORD = {8'hD5, {6{8'h55}}, 8'hFB};
    localparam logic [3:0]  IFG_W      = 4'(IFG_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_TERM,
        S_ABORT_T,
        S_DROP,
        S_IFG
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          gap_q, gap_d;
    logic [63:0]         txd_q, txd_d;
    logic [7:0]          txc_q, txc_d;
    logic [CNT_BITS-1:0] frames_q, frames_d;
    logic [15:0]         aborts_q, aborts_d;
    logic                underrun_q, underrun_d;
    logic                drop_q, drop_d;

    // Last word with n valid bytes: data below lane n, /T/ in lane n, idles above.
    function automatic logic [63:0] end_word(input logic [63:0] d, input logic [2:0] n);
        logic [63:0] w;
        w = IDLE_WORD;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(n))
                w[8*k +: 8] = d[8*k +: 8];
            else if (k == int'(n))
                w[8*k +: 8] = 8'hFD;
        end
        return w;
    endfunction

    // A word offered while the link is down stays with the client for the next frame.
    assign tx_ready = ((state_q == S_DATA) && link_up) || (state_q == S_DROP);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        txd_d      = IDLE_WORD;
        txc_d      = 8'hFF;
        frames_d   = frames_q;
        aborts_d   = aborts_q;
        underrun_d = underrun_q;
        drop_d     = drop_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid && link_up) begin
                    txd_d   = START_WORD;
                    txc_d   = 8'h01;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!tx_valid || !link_up) begin
                    txd_d   = ERR_WORD;
                    txc_d   = 8'hFF;
                    drop_d  = !tx_valid;
                    state_d = S_ABORT_T;
                    if (!tx_valid)
                        underrun_d = 1'b1;
                end else if (!tx_end) begin
                    txd_d = tx_data;
                    txc_d = 8'h00;
                end else if (tx_bytes == 3'd0) begin
                    txd_d   = tx_data;
                    txc_d   = 8'h00;
                    state_d = S_TERM;
                end else begin
                    txd_d    = end_word(tx_data, tx_bytes);
                    txc_d    = 8'hFF << tx_bytes;
                    frames_d = frames_q + 1'b1;
                    state_d  = S_IFG;
                    gap_d    = IFG_W;
                end
            end
            S_TERM: begin
                txd_d    = TERM_WORD;
                frames_d = frames_q + 1'b1;
                state_d  = S_IFG;
                gap_d    = IFG_W;
            end
            S_ABORT_T: begin
                txd_d = TERM_WORD;
                if (aborts_q != 16'hFFFF)
                    aborts_d = aborts_q + 16'd1;
                if (drop_q) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_IFG;
                    gap_d   = IFG_W;
                end
            end
            S_DROP: begin
                if (tx_valid && tx_end) begin
                    state_d = S_IFG;
                    gap_d   = IFG_W;
                end
            end
            S_IFG: begin
                if (gap_q <= 4'd1)
                    state_d = S_IDLE;
                else
                    gap_d = gap_q - 4'd1;
            end
            default: begin
                state_d = S_IFG;
                gap_d   = IFG_W;
            end
        endcase
    end

    always_ff @(posedge mgt_clk) begin
        if (reset) begin
            state_q    <= S_IFG;
            gap_q      <= IFG_W;
            txd_q      <= IDLE_WORD;
            txc_q      <= 8'hFF;
            frames_q   <= '0;
            aborts_q   <= '0;
            underrun_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            frames_q   <= frames_d;
            aborts_q   <= aborts_d;
            underrun_q <= underrun_d;
            drop_q     <= drop_d;
        end
    end

    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign frames_sent = frames_q;
    assign abort_count = aborts_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Scoreboard bench for xgmii_tx_framer: frames are expanded at lane level into
// expected XGMII words; a monitor pops and compares every non-idle output word.
module tb_xgmii_tx_framer;

    localparam int IFG = 3;
    localparam logic [63:0] IDLE_W  = {8{8'h07}};
    localparam logic [63:0] START_W = {8'hD5, {6{8'h55}}, 8'hFB};

    logic        mgt_clk = 1'b0;
    logic        reset;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_end;
    logic [2:0]  tx_bytes;
    logic        tx_ready;
    logic        link_up;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] frames_sent;
    logic [15:0] abort_count;
    logic        underrun;

    always #5 mgt_clk = ~mgt_clk;

    xgmii_tx_framer #(.IFG_WORDS(IFG), .CNT_BITS(32)) dut (
        .mgt_clk     (mgt_clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_end      (tx_end),
        .tx_bytes    (tx_bytes),
        .tx_ready    (tx_ready),
        .link_up     (link_up),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .frames_sent (frames_sent),
        .abort_count (abort_count),
        .underrun    (underrun)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pl[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_frames = 0;
    int          exp_aborts = 0;
    int          exp_underrun = 0;
    bit          mon_en = 1'b0;
    int          idle_run = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Every cycle with a non-idle word is a DUT output event.
    always @(negedge mgt_clk) begin
        if (mon_en) begin
            if (xgmii_txd === IDLE_W && xgmii_txc === 8'hFF) begin
                idle_run++;
            end else begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h/%h, expected idle", xgmii_txd, xgmii_txc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("txd", xgmii_txd, mon_e.d);
                    check("txc", 64'(xgmii_txc), 64'(mon_e.c));
                    if (mon_e.gap >= 0)
                        check("ifg_gap", 64'(idle_run), 64'(mon_e.gap));
                end
                idle_run = 0;
            end
        end
    end

    // Lane-level view: start+preamble, payload, optional error word, /T/, idle pad.
    task automatic push_lanes(input int from, input int to_excl, input bit aborted, input int gap);
        logic [8:0] lq[$];
        lq.push_back({1'b1, 8'hFB});
        repeat (6) lq.push_back({1'b0, 8'h55});
        lq.push_back({1'b0, 8'hD5});
        for (int i = from; i < to_excl; i++) lq.push_back({1'b0, pl[i]});
        if (aborted) repeat (8) lq.push_back({1'b1, 8'hFE});
        lq.push_back({1'b1, 8'hFD});
        while (lq.size() % 8 != 0) lq.push_back({1'b1, 8'h07});
        for (int w = 0; w < lq.size() / 8; w++) begin
            exp_t e;
            for (int k = 0; k < 8; k++) begin
                e.d[8*k +: 8] = lq[8*w+k][7:0];
                e.c[k]        = lq[8*w+k][8];
            end
            e.gap = (w == 0) ? gap : -1;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [63:0] word_of(input int w, input int len);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            r[8*k +: 8] = (8*w + k < len) ? pl[8*w+k] : 8'($urandom);
        return r;
    endfunction

    task automatic wait_accept(inout int ready_cnt, output bit ok);
        int  cyc = 0;
        bit  acc = 1'b0;
        while (!acc && cyc < 200) begin
            @(negedge mgt_clk);
            if (tx_ready) ready_cnt++;
            acc = tx_valid && tx_ready;
            @(posedge mgt_clk);
            #1;
            cyc++;
        end
        ok = acc;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no handshake in %0d cycles, expected one", cyc);
        end
    endtask

    // kind 0: normal, 1: underrun before word j, 2: link drop before word j.
    task automatic send_frame(input int len, input int kind, input int j, input int hold,
                              input int pause, input int gap);
        int n_w = (len + 7) / 8;
        int ready_cnt = 0;
        bit ok;
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        if (kind == 1 && j >= 1) begin
            push_lanes(0, 8*j, 1'b1, gap);
            exp_aborts++;
            exp_underrun = 1;
        end else if (kind == 2 && j >= 1) begin
            push_lanes(0, 8*j, 1'b1, gap);
            push_lanes(8*j, len, 1'b0, -1);
            exp_aborts++;
            exp_frames++;
        end else begin
            push_lanes(0, len, 1'b0, (kind == 2) ? -1 : gap);
            exp_frames++;
        end
        tx_valid = 1'b0;
        repeat (pause) begin @(posedge mgt_clk); #1; end
        for (int w = 0; w < n_w; w++) begin
            if (w == j && kind == 1) begin
                tx_valid = 1'b0;
                tx_data  = {$urandom, $urandom};
                repeat (hold) begin @(posedge mgt_clk); #1; end
            end
            tx_data  = word_of(w, len);
            tx_valid = 1'b1;
            tx_end   = (w == n_w - 1);
            tx_bytes = 3'(len % 8);
            if (w == j && kind == 2) begin
                link_up = 1'b0;
                repeat (hold) begin
                    @(negedge mgt_clk);
                    check("ready_link_down", 64'(tx_ready), 64'd0);
                    @(posedge mgt_clk);
                    #1;
                end
                link_up = 1'b1;
            end
            wait_accept(ready_cnt, ok);
            if (!ok) break;
        end
        tx_valid = 1'b0;
        tx_end   = 1'b0;
        if (kind == 0)
            check("ready_cycles", 64'(ready_cnt), 64'(n_w));
    endtask

    task automatic drain_and_check();
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 500) begin @(posedge mgt_clk); cyc++; end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (IFG + 4) @(posedge mgt_clk);
        #1;
        check("frames_sent", 64'(frames_sent), 64'(exp_frames));
        check("abort_count", 64'(abort_count), 64'(exp_aborts));
        check("underrun", 64'(underrun), 64'(exp_underrun));
    endtask

    initial begin
        repeat (60000) @(posedge mgt_clk);
        fails++;
        $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int  len, kind, j, pause, gap, rc;
        bit  prev_normal, ok;
        exp_t e;
        reset    = 1'b1;
        link_up  = 1'b1;
        tx_valid = 1'b0;
        tx_end   = 1'b0;
        tx_bytes = 3'd0;
        tx_data  = '0;
        repeat (3) @(posedge mgt_clk);
        #1;
        @(negedge mgt_clk);
        check("reset_txd", xgmii_txd, IDLE_W);
        check("reset_txc", 64'(xgmii_txc), 64'hFF);
        check("reset_frames", 64'(frames_sent), 64'd0);
        check("reset_aborts", 64'(abort_count), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        check("reset_ready", 64'(tx_ready), 64'd0);
        @(posedge mgt_clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        send_frame(11, 0, 0, 0, 0, -1);
        drain_and_check();
        send_frame(16, 0, 0, 0, 0, -1);
        drain_and_check();
        send_frame(20, 0, 0, 0, 0, -1);
        send_frame(8, 0, 0, 0, 0, IFG);
        send_frame(13, 0, 0, 0, 0, IFG);
        drain_and_check();
        send_frame(24, 1, 1, 2, 0, -1);
        drain_and_check();
        send_frame(10, 2, 0, 4, 0, -1);
        drain_and_check();
        send_frame(30, 2, 2, 3, 0, -1);
        drain_and_check();

        prev_normal = 1'b0;
        for (int f = 0; f < 40; f++) begin
            len   = $urandom_range(1, 64);
            rc    = $urandom_range(0, 9);
            kind  = 0;
            j     = 0;
            if ((len + 7) / 8 >= 2 && rc >= 7) begin
                kind = (rc == 7) ? 1 : 2;
                j    = $urandom_range(1, (len + 7) / 8 - 1);
            end
            pause = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            gap   = (prev_normal && pause == 0) ? IFG : -1;
            send_frame(len, kind, j, $urandom_range(1, 3), pause, gap);
            prev_normal = (kind != 1);
        end
        drain_and_check();

        pl.delete();
        for (int i = 0; i < 24; i++) pl.push_back(8'($urandom));
        e.d = START_W; e.c = 8'h01; e.gap = -1;
        exp_q.push_back(e);
        e.d = word_of(0, 24); e.c = 8'h00;
        exp_q.push_back(e);
        tx_data  = e.d;
        tx_valid = 1'b1;
        tx_end   = 1'b0;
        tx_bytes = 3'd0;
        rc = 0;
        wait_accept(rc, ok);
        reset   = 1'b1;
        tx_data = word_of(1, 24);
        @(posedge mgt_clk);
        #1;
        @(negedge mgt_clk);
        check("midreset_txd", xgmii_txd, IDLE_W);
        check("midreset_txc", 64'(xgmii_txc), 64'hFF);
        check("midreset_frames", 64'(frames_sent), 64'd0);
        check("midreset_aborts", 64'(abort_count), 64'd0);
        check("midreset_underrun", 64'(underrun), 64'd0);
        check("midreset_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tx_valid = 1'b0;
        @(posedge mgt_clk);
        #1;
        reset = 1'b0;
        exp_frames = 0;
        exp_aborts = 0;
        exp_underrun = 0;
        send_frame(9, 0, 0, 0, 0, -1);
        drain_and_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
